// File: rtl/dmem_responder_if.sv
// Request/response bus between the MEM stage and the multi-cycle data memory.
// The pipeline drives the request side; the responder returns data, stall and done.
interface dmem_responder_if;
  logic        memread;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        done;

  modport master (
    output memread, memwrite, addr, wdata,
    input  rdata, stall, done
  );

  modport slave (
    input  memread, memwrite, addr, wdata,
    output rdata, stall, done
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: fixed-latency access with
// pipeline stall, sticky error flag and saturating performance counters.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 3,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus,
  output logic             err,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LOAD = 4'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic [AW-1:0]   idx;
  logic [31:0]     wbuf;
  logic            op_rd;
  logic            op_wr;
  logic            bad;
  logic            req;
  logic            req_bad;
  logic            stall_int;
  logic [31:0]     mem [DEPTH];

  // Misaligned, beyond the array, or both read and write at once.
  function automatic logic addr_bad(input logic [31:0] a, input logic rd, input logic wr);
    return (a[1:0] != 2'b00) || (a[31:AW+2] != {(30-AW){1'b0}}) || (rd && wr);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_ONE;
  endfunction

  // Request decode and stall; stall is forced low while reset is asserted.
  always_comb begin
    req       = bus.memread | bus.memwrite;
    req_bad   = addr_bad(bus.addr, bus.memread, bus.memwrite);
    stall_int = 1'b0;
    if (rst) begin
      stall_int = ((state == IDLE) && req) || (state == BUSY);
    end else begin
      stall_int = 1'b0;
    end
  end

  assign bus.stall = stall_int;

  // Access FSM, registered read data, done pulse, error flag and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      idx       <= {AW{1'b0}};
      wbuf      <= 32'h0000_0000;
      op_rd     <= 1'b0;
      op_wr     <= 1'b0;
      bad       <= 1'b0;
      bus.rdata <= 32'h0000_0000;
      bus.done  <= 1'b0;
      err       <= 1'b0;
      rd_cnt    <= {CNT_W{1'b0}};
      wr_cnt    <= {CNT_W{1'b0}};
      stall_cnt <= {CNT_W{1'b0}};
    end else begin
      bus.done <= 1'b0;
      if (stall_int) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
      case (state)
        IDLE: begin
          if (req) begin
            idx   <= bus.addr[AW+1:2];
            wbuf  <= bus.wdata;
            op_rd <= bus.memread;
            op_wr <= bus.memwrite;
            bad   <= req_bad;
            err   <= err | req_bad;
            cnt   <= LOAD;
            state <= BUSY;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (op_rd) begin
              bus.rdata <= bad ? 32'h0000_0000 : mem[idx];
            end
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          // The request still present here belongs to the completing instruction.
          if (op_rd) rd_cnt <= sat_inc(rd_cnt);
          if (op_wr) wr_cnt <= sat_inc(wr_cnt);
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Write commit on the edge entering DONE; contents are never reset.
  always_ff @(posedge clk) begin
    if ((state == BUSY) && (cnt == 4'd0) && op_wr && !bad) begin
      mem[idx] <= wbuf;
    end
  end

endmodule
